// File: rtl/cart_fetch_pkg.sv
// Shared types for the cartridge ROM fetch buffer: word/data widths,
// controller states and the layout of one buffer entry.
package cart_fetch_pkg;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEMAND,
        ST_PREFETCH
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/cart_rom_fetch_if.sv
// Word-wide memory read port: level-held request, one-cycle ack carrying the data.
// master drives the request side, slave is the memory controller.
interface cart_rom_fetch_if;
    import cart_fetch_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/cart_fetch_entry.sv
// One buffer entry: valid/tag/data register plus a zero-latency tag compare.
// Write takes one cycle; clear has priority over write.
module cart_fetch_entry
    import cart_fetch_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] look_tag,
    output logic              match,
    output entry_t            q
);
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q.valid <= 1'b0;
        end else if (wr) begin
            q <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
        end
    end

    assign match = q.valid && (q.tag == look_tag);
endmodule

// File: rtl/cart_rom_fetch.sv
// Two-entry ROM word buffer for the cart bus: demand fill plus next-word prefetch.
// cart_do/hit are combinational from mbc_addr; memory requests wait for ack or timeout.
module cart_rom_fetch
    import cart_fetch_pkg::*;
#(
    parameter bit          PREFETCH = 1'b1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce_cpu,
    input  logic                rd,
    input  logic [22:0]         mbc_addr,
    input  logic                flush,
    cart_rom_fetch_if.master    mem,
    output logic [7:0]          cart_do,
    output logic                hit,
    output logic [7:0]          err_cnt
);
    fetch_state_t      state;
    logic [7:0]        wait_cnt;
    logic              discard;
    entry_t            e0_q, e1_q;
    logic              e0_match, e1_match;
    logic [ADDR_W-1:0] word, pf_addr;
    logic [DATA_W-1:0] hit_data;
    logic              pf_hit, fill_ok, wr0, wr1;

    assign word     = mbc_addr[22:1];
    assign hit      = e0_match | e1_match;
    assign hit_data = e0_match ? e0_q.data : e1_q.data;
    assign cart_do  = !hit ? 8'hFF : (mbc_addr[0] ? hit_data[15:8] : hit_data[7:0]);

    // The prefetch target is derived from the just-served demand address.
    assign pf_addr = mem.mem_addr + 22'd1;
    assign pf_hit  = (e0_q.valid && (e0_q.tag == pf_addr)) ||
                     (e1_q.valid && (e1_q.tag == pf_addr));

    // Data returned after a flush belongs to stale mapping state and is dropped.
    assign fill_ok = mem.mem_req && mem.mem_ack && !flush && !discard;
    assign wr0     = fill_ok && (state == ST_DEMAND);
    assign wr1     = fill_ok && (state == ST_PREFETCH);

    cart_fetch_entry u_e0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .clr(flush), .wr(wr0),
        .wr_tag(mem.mem_addr), .wr_data(mem.mem_rdata), .look_tag(word),
        .match(e0_match), .q(e0_q)
    );

    cart_fetch_entry u_e1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .clr(flush), .wr(wr1),
        .wr_tag(mem.mem_addr), .wr_data(mem.mem_rdata), .look_tag(word),
        .match(e1_match), .q(e1_q)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            wait_cnt     <= '0;
            err_cnt      <= '0;
            discard      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_cpu && rd && !hit && !flush) begin
                        state        <= ST_DEMAND;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= word;
                        wait_cnt     <= '0;
                        discard      <= 1'b0;
                    end
                end
                ST_DEMAND, ST_PREFETCH: begin
                    if (mem.mem_req) begin
                        if (flush) discard <= 1'b1;
                        if (mem.mem_ack) begin
                            mem.mem_req <= 1'b0;
                            state <= ((state == ST_DEMAND) && PREFETCH && !flush && !discard)
                                     ? ST_PREFETCH : ST_IDLE;
                        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                            mem.mem_req <= 1'b0;
                            state       <= ST_IDLE;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else if (state == ST_DEMAND) begin
                        state <= ST_IDLE;
                    end else if (flush || pf_hit) begin
                        // This request-low cycle also provides the gap between requests.
                        state <= ST_IDLE;
                    end else begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= pf_addr;
                        wait_cnt     <= '0;
                        discard      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cart_rom_fetch.sv
// Randomized scoreboard bench for cart_rom_fetch against a two-entry buffer model.
module tb_cart_rom_fetch;
    localparam int TO = 16;

    typedef struct packed {
        logic       h;
        logic [7:0] b;
        logic [7:0] e;
    } rd_exp_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_cpu, rd;
    logic [22:0] mbc_addr;
    logic        flush, flush_stim, flush_resp;
    logic [7:0]  cart_do, err_cnt;
    logic        hit;

    cart_rom_fetch_if mem_if ();

    assign flush = flush_stim | flush_resp;

    cart_rom_fetch #(.PREFETCH(1'b1), .TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .rd(rd),
        .mbc_addr(mbc_addr), .flush(flush), .mem(mem_if),
        .cart_do(cart_do), .hit(hit), .err_cnt(err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    logic [21:0] exp_req[$];
    rd_exp_t     exp_rd[$];
    int          exp_len[$];
    int          errors = 0;
    int          checks = 0;
    int          expired_cnt = 0;
    int          resp_mode = 0;   // 0 normal, 1 never ack, 2 ack together with flush
    logic        probe_vld = 1'b0;
    logic        done = 1'b0;

    // Reference model: which words the buffer holds, and the error count.
    logic        m_v[2];
    logic [21:0] m_tag[2];
    int          m_err = 0;

    function automatic logic [15:0] memfn(input logic [21:0] w);
        if (w == 22'h002000) return 16'hBEEF;
        if (w == 22'h002001) return 16'h1234;
        return {w[7:0] ^ 8'hA5, w[15:8] + w[21:14]};
    endfunction

    function automatic logic m_hit(input logic [21:0] w);
        return (m_v[0] && m_tag[0] == w) || (m_v[1] && m_tag[1] == w);
    endfunction

    task automatic m_clear();
        m_v[0] = 1'b0;
        m_v[1] = 1'b0;
    endtask

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (!(q >= 3 && exp_req.size() == 0) && n < 400) begin
            @(posedge clk_sys); #1;
            q = mem_if.mem_req ? 0 : q + 1;
            n++;
        end
        if (n >= 400) expired_cnt++;
    endtask

    task automatic probe(input logic [22:0] a);
        rd_exp_t     x;
        logic [21:0] w;
        logic [15:0] d;
        w   = a[22:1];
        d   = memfn(w);
        x.h = m_hit(w);
        x.b = !x.h ? 8'hFF : (a[0] ? d[15:8] : d[7:0]);
        x.e = 8'(m_err);
        mbc_addr = a;
        exp_rd.push_back(x);
        probe_vld = 1'b1;
        @(posedge clk_sys); #1;
        probe_vld = 1'b0;
    endtask

    task automatic do_read(input logic [22:0] a, input logic ce);
        logic [21:0] w, pf;
        w = a[22:1];
        if (ce && !m_hit(w)) begin
            exp_req.push_back(w);
            if (resp_mode == 1) begin
                exp_len.push_back(TO);
                if (m_err != 255) m_err++;
            end else if (resp_mode == 2) begin
                m_clear();
            end else begin
                m_v[0] = 1'b1; m_tag[0] = w;
                pf = w + 22'd1;
                if (!m_hit(pf)) begin
                    exp_req.push_back(pf);
                    m_v[1] = 1'b1; m_tag[1] = pf;
                end
            end
        end
        mbc_addr = a; rd = 1'b1; ce_cpu = ce;
        @(posedge clk_sys); #1;
        rd = 1'b0; ce_cpu = 1'b1;
        wait_quiet();
        probe(a);
    endtask

    // Memory responder.
    initial begin
        int dly = 0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        flush_resp       = 1'b0;
        forever begin
            @(negedge clk_sys);
            mem_if.mem_ack = 1'b0;
            flush_resp     = 1'b0;
            if (mem_if.mem_req && resp_mode != 1) begin
                if (dly == 0) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = memfn(mem_if.mem_addr);
                    flush_resp       = (resp_mode == 2);
                    dly = (resp_mode == 2) ? 2 : int'($urandom_range(0, 4));
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: sole owner of the check counters.
    initial begin
        logic        prev = 1'b0;
        int          hi_len = 0;
        int          seen_exp = 0;
        int          l;
        logic [21:0] held = '0;
        logic [21:0] e;
        rd_exp_t     r;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                checks++;
                if (mem_if.mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_req: mem_req=%b expected 0", mem_if.mem_req);
                end
            end
            if (mem_if.mem_req === 1'b1) begin
                checks++;
                if (!prev) begin
                    hi_len = 1;
                    held   = mem_if.mem_addr;
                    if (exp_req.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: mem_addr=%h expected no request", mem_if.mem_addr);
                    end else begin
                        e = exp_req.pop_front();
                        if (mem_if.mem_addr !== e) begin
                            errors++;
                            $display("FAIL req_addr: mem_addr=%h expected %h", mem_if.mem_addr, e);
                        end
                    end
                end else begin
                    hi_len++;
                    if (mem_if.mem_addr !== held) begin
                        errors++;
                        $display("FAIL req_stable: mem_addr=%h expected %h", mem_if.mem_addr, held);
                    end
                end
            end else if (prev && exp_len.size() > 0) begin
                l = exp_len.pop_front();
                checks++;
                if (hi_len != l) begin
                    errors++;
                    $display("FAIL timeout_len: mem_req high %0d cycles expected %0d", hi_len, l);
                end
            end
            prev = (mem_if.mem_req === 1'b1);
            if (probe_vld) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL read_probe: no expectation queued for addr %h", mbc_addr);
                end else begin
                    r = exp_rd.pop_front();
                    if (hit !== r.h || cart_do !== r.b || err_cnt !== r.e) begin
                        errors++;
                        $display("FAIL read addr=%h: hit=%b cart_do=%h err_cnt=%0d expected hit=%b cart_do=%h err_cnt=%0d",
                                 mbc_addr, hit, cart_do, err_cnt, r.h, r.b, r.e);
                    end
                end
            end
            if (expired_cnt != seen_exp) begin
                checks++;
                errors++;
                seen_exp = expired_cnt;
                $display("FAIL wait_bound: DUT did not settle, expired=%0d expected 0", expired_cnt);
            end
            if (done) begin
                checks++;
                if (exp_req.size() != 0 || exp_rd.size() != 0 || exp_len.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: req=%0d rd=%0d len=%0d expected 0", exp_req.size(), exp_rd.size(), exp_len.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        logic [22:0] a;
        int          n;
        m_clear();
        reset_n = 1'b0; ce_cpu = 1'b1; rd = 1'b0; flush_stim = 1'b0; mbc_addr = '0;
        repeat (2) @(posedge clk_sys);
        #1;
        probe(23'h000000);
        reset_n = 1'b1;

        // Cold miss, prefetch, hit without request.
        do_read(23'h004001, 1'b1);
        do_read(23'h004002, 1'b1);
        // Prefetch wraps at the top of the word space.
        do_read({22'h3FFFFF, 1'b0}, 1'b1);
        do_read(23'h000001, 1'b1);

        a = 23'h004000;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) a = 23'($urandom);
            else a = a + 23'($urandom_range(0, 3));
            do_read(a, $urandom_range(0, 7) != 0);
        end

        // rd in the flush cycle is ignored; the next rd re-requests.
        mbc_addr = 23'h020000; rd = 1'b1; flush_stim = 1'b1;
        @(posedge clk_sys); #1;
        rd = 1'b0; flush_stim = 1'b0;
        m_clear();
        wait_quiet();
        probe(23'h020000);
        do_read(23'h020000, 1'b1);

        // Flush coincident with ack: nothing filled, then a re-request.
        resp_mode = 2;
        do_read(23'h010000, 1'b1);
        resp_mode = 0;
        do_read(23'h010000, 1'b1);

        // Timeouts and saturation.
        resp_mode = 1;
        do_read(23'h030001, 1'b1);
        for (int i = 0; i < 256; i++) do_read(23'h100000 + 23'(2 * i), 1'b1);
        resp_mode = 0;
        do_read(23'h000100, 1'b1);

        // Reset while a demand request is outstanding.
        resp_mode = 1;
        exp_req.push_back(22'h000200);
        mbc_addr = 23'h000400; rd = 1'b1;
        @(posedge clk_sys); #1;
        rd = 1'b0;
        n = 0;
        while (!mem_if.mem_req && n < 20) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 20) expired_cnt++;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b0;
        m_clear();
        m_err = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        resp_mode = 0;
        probe(23'h000100);
        probe(23'h000400);
        do_read(23'h000400, 1'b1);

        wait_quiet();
        done = 1'b1;
    end
endmodule

// File: doc/cart_rom_fetch.md
CART_ROM_FETCH -- requirements
Module: cart_rom_fetch

Interface
REQ-001 SHALL have parameter PREFETCH, default 1: enables next-word prefetch after each demand fill.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack, range 1..255.
REQ-003 SHALL have port clk_sys, input, 1: the single system clock.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ce_cpu, input, 1: CPU clock enable that qualifies rd sampling.
REQ-006 SHALL have port rd, input, 1: ROM read strobe from the mapper, cart_rd & ~cart_a15.
REQ-007 SHALL have port mbc_addr, input, 23: mapper byte address into ROM.
REQ-008 SHALL have port flush, input, 1: invalidate the buffer on cart load, mapper switch or savestate load.
REQ-009 SHALL have port mem_req, output, 1: memory request, level-held until ack.
REQ-010 SHALL have port mem_addr, output, 22: word address, stable while mem_req is high.
REQ-011 SHALL have port mem_ack, input, 1: one-cycle pulse, data valid in that cycle.
REQ-012 SHALL have port mem_rdata, input, 16: memory read data.
REQ-013 SHALL have port cart_do, output, 8: ROM byte to the cart bus.
REQ-014 SHALL have port hit, output, 1: the current mbc_addr word is held in the buffer.
REQ-015 SHALL have port err_cnt, output, 8: saturating count of timeouts.

Function
REQ-016 SHALL hold two entries {valid, tag[21:0], data[15:0]}: E0 filled by demand, E1 filled by prefetch.
REQ-017 SHALL compute word = mbc_addr[22:1]; hit = any valid entry whose tag equals word; E0 has priority if both match.
REQ-018 SHALL drive cart_do combinationally: hit data[7:0] when mbc_addr[0]=0, data[15:8] when mbc_addr[0]=1, 8'hFF on miss.
REQ-019 SHALL implement FSM IDLE, DEMAND, PREFETCH.
REQ-020 SHALL go IDLE->DEMAND when ce_cpu & rd & ~hit & ~flush; mem_addr=word, mem_req=1 from the next cycle.
REQ-021 SHALL on mem_ack in DEMAND write E0 {1, mem_addr, mem_rdata}; mem_req=0 next cycle; go to PREFETCH if PREFETCH=1, otherwise IDLE.
REQ-022 SHALL in PREFETCH request mem_addr+1, wrapping 22'h3FFFFF to 0, and skip the request if that word already hits; on ack fill E1 and go IDLE.
REQ-023 SHALL never abort a handshake for a new miss; a demand miss arising during PREFETCH is served from IDLE after completion.
REQ-024 SHALL keep mem_req low for at least one cycle between consecutive requests.
REQ-025 SHALL count wait cycles while mem_req is high; at TIMEOUT, drop mem_req, fill nothing, increment err_cnt (saturate 255), go IDLE.
REQ-026 SHALL on flush clear both valid bits; an outstanding transaction completes its handshake, but its data is discarded.
REQ-027 SHALL give flush priority when flush and mem_ack coincide: no fill occurs and valid stays 0.
REQ-028 SHALL ignore rd in the flush cycle; the miss is re-evaluated on the next ce_cpu.
REQ-029 SHALL have hit use the live mbc_addr, with no added latency.

Reset
REQ-030 SHALL asynchronously on reset_n=0 set state IDLE, mem_req 0, mem_addr 0, both valid 0, wait counter 0, err_cnt 0, cart_do 8'hFF, hit 0.
REQ-031 SHALL drop mem_req at once if reset is asserted mid-transaction, with no fill.

Structure
REQ-032 SHALL place the FSM state enum, ADDR_W=22, DATA_W=16 and the entry struct typedef in shared package cart_fetch_pkg.
REQ-033 SHALL use one sub-module, cart_fetch_entry (valid/tag/data register plus tag compare), instantiated twice.

Verification
REQ-034 SHALL test a cold miss: rd, mbc_addr=23'h004001 -> mem_req with mem_addr 22'h002000; ack data 16'hBEEF -> cart_do=8'hBE, hit=1.
REQ-035 SHALL test prefetch: after REQ-034 -> second request with mem_addr 22'h002001; ack 16'h1234; mbc_addr=23'h004002 -> cart_do=8'h34, no new request.
REQ-036 SHALL test wrap: demand at word 22'h3FFFFF -> prefetch mem_addr 22'h000000.
REQ-037 SHALL test timeout: withhold ack for TIMEOUT cycles -> mem_req falls, err_cnt=1, hit=0; 256 timeouts -> err_cnt=255.
REQ-038 SHALL test flush with ack in the same cycle -> hit=0, cart_do=8'hFF; the next rd re-requests the same word.
REQ-039 SHALL test reset mid-DEMAND -> mem_req=0 immediately, err_cnt=0, no entry valid after release.
